div_tc_32_16: RTL and testbench
===============================

DIV_TC_32_16 -- requirements
Module: div_tc_32_16

Interface
REQ-001 SHALL have parameter DIVIDEND_W, default 32, dividend and quotient width.
REQ-002 SHALL have parameter DIVISOR_W, default 16, divisor and remainder width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operands valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  DIVIDEND_W  signed two's-complement dividend.
REQ-008 SHALL have port b  input  DIVISOR_W  signed two's-complement divisor.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port quotient  output  DIVIDEND_W  signed quotient.
REQ-012 SHALL have port remainder  output  DIVISOR_W  signed remainder.
REQ-013 SHALL have port div_by_zero  output  1  flag, valid with out_valid.
REQ-014 SHALL have port overflow  output  1  flag, valid with out_valid.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-016 SHALL assert in_ready only in IDLE; an input handshake is in_valid & in_ready on a rising edge.
REQ-017 SHALL on input handshake register |a|, |b|, sign(a), sign(b) and move IDLE->CALC with iteration counter = 0.
REQ-018 SHALL in CALC perform one unsigned restoring-division step per cycle, MSB first, for exactly DIVIDEND_W cycles, then move CALC->FIX.
REQ-019 SHALL in FIX (1 cycle) negate quotient when sign(a) != sign(b), give remainder the sign of a, then move FIX->DONE.
REQ-020 SHALL produce truncation-toward-zero results: a = quotient*b + remainder, |remainder| < |b|.
REQ-021 SHALL assert out_valid exactly DIVIDEND_W+2 cycles after the input handshake edge (34 at defaults), for every operand pair.
REQ-022 SHALL hold quotient, remainder, flags and out_valid stable in DONE while out_ready is low.
REQ-023 SHALL on out_valid & out_ready move DONE->IDLE, deassert out_valid next cycle; in_ready rises the same cycle.
REQ-024 SHALL not accept a new operand pair until the previous result is consumed (single outstanding operation).
REQ-025 SHALL when b == 0 output quotient = all ones, remainder = a[DIVISOR_W-1:0], div_by_zero = 1, same latency.
REQ-026 SHALL when a = most-negative and b = -1 output quotient = most-negative (wrapped), remainder = 0, overflow = 1.
REQ-027 SHALL handle b = most-negative divisor (-32768) without internal overflow; absolute-value datapath is DIVISOR_W+1 bits wide.
REQ-028 SHALL hold div_by_zero and overflow at 0 for all other operand pairs.

Reset
REQ-029 SHALL on rst force state IDLE, counter 0, in_ready 1, out_valid 0, quotient 0, remainder 0, div_by_zero 0, overflow 0, asynchronously.
REQ-030 SHALL abandon any in-progress operation on reset mid-CALC/FIX/DONE; no result emitted after reset release.
REQ-031 SHALL accept operands on the first rising edge after rst deasserts.

Structure
REQ-032 SHALL place the state enum, default widths and the counter width ($clog2(DIVIDEND_W+1)) in package div_tc_pkg.
REQ-033 SHALL use one sub-module tc_abs (parameterised width, returns magnitude one bit wider plus sign) instantiated for a and b.
REQ-034 SHALL contain no combinational division operator; only shift/subtract per cycle.

Verification
REQ-035 SHALL check 100 / 7 -> quotient 14, remainder 2, flags 0, out_valid at handshake+34.
REQ-036 SHALL check -100 / 7 -> -14, -2; 100 / -7 -> -14, 2; -100 / -7 -> 14, -2.
REQ-037 SHALL check -2147483648 / -1 -> quotient 32'h8000_0000, remainder 0, overflow 1; and 5 / 0 -> quotient 32'hFFFF_FFFF, remainder 5, div_by_zero 1.
REQ-038 SHALL check -2147483648 / -32768 -> quotient 65536, remainder 0; 32767 / -32768 -> 0, 32767.
REQ-039 SHALL check backpressure: out_ready low 10 cycles -> outputs stable, in_ready 0; then back-to-back random pairs compared against a reference model using the / and % operators.
REQ-040 SHALL check rst pulsed at CALC cycle 10 -> out_valid never rises, in_ready 1 after release, next operation correct.

Source files
------------

// File: rtl/div_tc_32_16_pkg.sv
// Shared definitions for the signed 32/16 sequential divider.
package div_tc_pkg;

    localparam int DEF_DIVIDEND_W = 32;
    localparam int DEF_DIVISOR_W  = 16;

    // The iteration counter must be able to hold DIVIDEND_W itself (terminal count).
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_width(DEF_DIVIDEND_W);

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t CALC = 2'd1;
    localparam state_t FIX  = 2'd2;
    localparam state_t DONE = 2'd3;

endpackage

// File: rtl/div_tc_32_16_tc_abs.sv
// Two's-complement magnitude: result is one bit wider so the most-negative value fits.
module tc_abs #(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    output logic [W:0]   mag,
    output logic         neg
);

    // Sign-extend, then negate when negative.
    always_comb begin
        neg = x[W-1];
        mag = neg ? ((~{1'b1, x}) + 1'b1) : {1'b0, x};
    end

endmodule

// File: rtl/div_tc_32_16.sv
// Signed restoring divider, truncation toward zero, one quotient bit per cycle.
module div_tc_32_16
    import div_tc_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] a,
    input  logic [DIVISOR_W-1:0]  b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  overflow
);

    localparam int CW = cnt_width(DIVIDEND_W);
    localparam logic [CW-1:0] CNT_DONE = CW'(DIVIDEND_W);
    localparam logic [DIVIDEND_W-1:0] A_MIN = {1'b1, {(DIVIDEND_W-1){1'b0}}};

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [DIVIDEND_W-1:0] q;
    logic [DIVISOR_W-1:0]  r;
    logic [DIVISOR_W:0]    bmag;
    logic                  sa, sb, dbz, ovf;
    logic [DIVISOR_W-1:0]  a_lo;

    logic [DIVIDEND_W:0]   a_mag;
    logic [DIVISOR_W:0]    b_mag;
    logic                  a_neg, b_neg;

    logic [DIVISOR_W:0]    shifted;
    logic [DIVISOR_W+1:0]  diff;
    logic [DIVIDEND_W-1:0] q_step;
    logic [DIVISOR_W-1:0]  r_step;
    logic                  unused_bits;

    tc_abs #(.W(DIVIDEND_W)) u_abs_a (.x(a), .mag(a_mag), .neg(a_neg));
    tc_abs #(.W(DIVISOR_W))  u_abs_b (.x(b), .mag(b_mag), .neg(b_neg));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // |a| never exceeds 2^(W-1), so its top bit is always zero; the accepted
    // partial remainder is always below |b|, so diff's bit DIVISOR_W is zero too.
    assign unused_bits = ^{a_mag[DIVIDEND_W], diff[DIVISOR_W]};

    // One restoring step: shift in the next dividend bit, trial-subtract |b|.
    always_comb begin
        shifted = {r, q[DIVIDEND_W-1]};
        diff    = {1'b0, shifted} - {1'b0, bmag};
        if (!diff[DIVISOR_W+1]) begin
            r_step = diff[DIVISOR_W-1:0];
            q_step = {q[DIVIDEND_W-2:0], 1'b1};
        end else begin
            r_step = shifted[DIVISOR_W-1:0];
            q_step = {q[DIVIDEND_W-2:0], 1'b0};
        end
    end

    // Control FSM and datapath registers. CALC spends DIVIDEND_W step cycles
    // plus one terminal-count cycle, giving handshake-to-out_valid of DIVIDEND_W+2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            q           <= '0;
            r           <= '0;
            bmag        <= '0;
            sa          <= 1'b0;
            sb          <= 1'b0;
            dbz         <= 1'b0;
            ovf         <= 1'b0;
            a_lo        <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        q     <= a_mag[DIVIDEND_W-1:0];
                        r     <= '0;
                        bmag  <= b_mag;
                        sa    <= a_neg;
                        sb    <= b_neg;
                        dbz   <= (b == '0);
                        ovf   <= (a == A_MIN) && (b == '1);
                        a_lo  <= a[DIVISOR_W-1:0];
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (cnt == CNT_DONE) begin
                        state <= FIX;
                    end else begin
                        q   <= q_step;
                        r   <= r_step;
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    if (dbz) begin
                        quotient  <= '1;
                        remainder <= a_lo;
                    end else begin
                        quotient  <= (sa ^ sb) ? -q : q;
                        remainder <= sa ? -r : r;
                    end
                    div_by_zero <= dbz;
                    overflow    <= ovf;
                    state       <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_tc_32_16.sv
// Directed and random checks for div_tc_32_16.
module tb_div_tc_32_16;

    typedef struct {
        logic [31:0] a;
        logic [15:0] b;
        logic [31:0] q;
        logic [15:0] r;
        logic        dbz;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    div_tc_32_16 #(.DIVIDEND_W(32), .DIVISOR_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drives one operand pair now (caller is away from the clock edge), checks
    // latency and result, optionally holds out_ready low for hold cycles.
    task automatic run_op(input string nm, input vec_t v, input int hold);
        int lat;
        logic [31:0] sq;
        logic [15:0] sr;
        chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
        a = v.a; b = v.b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
        end
        if (!out_valid) begin
            chk({nm, " timeout"}, 32'(out_valid), 32'd1);
            return;
        end
        chk({nm, " latency"}, 32'(lat), 32'd34);
        chk({nm, " quotient"}, quotient, v.q);
        chk({nm, " remainder"}, 32'(remainder), 32'(v.r));
        chk({nm, " div_by_zero"}, 32'(div_by_zero), 32'(v.dbz));
        chk({nm, " overflow"}, 32'(overflow), 32'(v.ovf));
        sq = quotient; sr = remainder;
        if (hold > 0) begin
            out_ready = 1'b0;
            // a competing operand pair must not be taken while a result is pending
            a = 32'd7; b = 16'd1; in_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk({nm, " hold out_valid"}, 32'(out_valid), 32'd1);
                chk({nm, " hold in_ready"}, 32'(in_ready), 32'd0);
                chk({nm, " hold quotient"}, quotient, v.q);
                chk({nm, " hold remainder"}, 32'(remainder), 32'(sr));
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk({nm, " consumed out_valid"}, 32'(out_valid), 32'd0);
        chk({nm, " consumed in_ready"}, 32'(in_ready), 32'd1);
        chk({nm, " quotient kept"}, quotient, sq);
    endtask

    vec_t vecs[12];
    vec_t v;
    logic [31:0] ra;
    logic [15:0] rb;
    int          ea;
    shortint     eb;
    bit          seen;

    initial begin
        vecs[0]  = '{32'd100,      16'd7,           32'd14,          16'd2,           1'b0, 1'b0};
        vecs[1]  = '{32'(-100),    16'd7,           32'(-14),        16'(-2),         1'b0, 1'b0};
        vecs[2]  = '{32'd100,      16'(-7),         32'(-14),        16'd2,           1'b0, 1'b0};
        vecs[3]  = '{32'(-100),    16'(-7),         32'd14,          16'(-2),         1'b0, 1'b0};
        vecs[4]  = '{32'h8000_0000, 16'hFFFF,       32'h8000_0000,   16'd0,           1'b0, 1'b1};
        vecs[5]  = '{32'd5,        16'd0,           32'hFFFF_FFFF,   16'd5,           1'b1, 1'b0};
        vecs[6]  = '{32'h8000_0000, 16'h8000,       32'd65536,       16'd0,           1'b0, 1'b0};
        vecs[7]  = '{32'd32767,    16'h8000,        32'd0,           16'd32767,       1'b0, 1'b0};
        vecs[8]  = '{32'(-7),      16'd0,           32'hFFFF_FFFF,   16'hFFF9,        1'b1, 1'b0};
        vecs[9]  = '{32'd0,        16'd5,           32'd0,           16'd0,           1'b0, 1'b0};
        vecs[10] = '{32'h8000_0000, 16'd1,          32'h8000_0000,   16'd0,           1'b0, 1'b0};
        vecs[11] = '{32'd7,        16'd100,         32'd0,           16'd7,           1'b0, 1'b0};

        // asynchronous reset values
        #2 rst = 1'b1;
        #1;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset quotient", quotient, 32'd0);
        chk("reset remainder", 32'(remainder), 32'd0);
        chk("reset flags", {30'd0, div_by_zero, overflow}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // first vector is presented in the same cycle reset releases
        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i], 0);
        end

        // backpressure: 1234567 / -321 = -3846 rem 1
        v = '{32'd1234567, 16'(-321), 32'(-3846), 16'd1, 1'b0, 1'b0};
        run_op("backpressure", v, 10);

        // back-to-back random pairs against the language operators
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = 16'($urandom);
            if (i % 5 == 0) ra = 32'($signed(ra) >>> 12);
            if (rb == 16'd0) rb = 16'd3;
            if (ra == 32'h8000_0000 && rb == 16'hFFFF) rb = 16'd3;
            ea = int'(ra);
            eb = shortint'(rb);
            v.a = ra; v.b = rb;
            v.q = 32'(ea / int'(eb));
            v.r = 16'(ea % int'(eb));
            v.dbz = 1'b0; v.ovf = 1'b0;
            run_op($sformatf("rand%0d", i), v, 0);
        end

        // reset at CALC cycle 10 abandons the operation
        a = 32'd999; b = 16'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midreset in_ready", 32'(in_ready), 32'd1);
        chk("midreset quotient", quotient, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("midreset no out_valid", 32'(seen), 32'd0);
        v = '{32'd1000, 16'(-3), 32'(-333), 16'd1, 1'b0, 1'b0};
        run_op("after reset", v, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1);
    end

endmodule
